vsc_ram_responder: RTL and testbench

//  Memory-side responder for the VerySimpleCPU RAM interface (addr_toRAM/wrEn/data_toRAM/data_fromRAM).

---
 rtl/vsc_pkg.sv | 20 ++
 rtl/vsc_ram_array.sv | 40 ++++
 rtl/vsc_ram_responder.sv | 145 ++++++++++++++
 tb/tb_vsc_ram_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vsc_pkg.sv
// Shared types and defaults for the VerySimpleCPU RAM responder.
package vsc_pkg;

  localparam int WORD_W = 32;
  localparam int DEF_SIZE = 14;
  localparam logic [DEF_SIZE-1:0] DEF_HALT_ADDR = 14'h3FFF;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_CLEAR,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } vsc_state_e;

  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    return (v == '1) ? v : v + WORD_W'(1);
  endfunction

endpackage

// File: rtl/vsc_ram_array.sv
// 2^AW x DW synchronous store: one write port, two registered read-first read ports.
module vsc_ram_array #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic          re_b,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_a_q;
  logic [DW-1:0] rdata_b_q;

  // Storage carries no reset so a reset never disturbs a loaded program.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= mem_q[raddr_a];
      if (re_b) rdata_b_q <= mem_q[raddr_b];
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: rtl/vsc_ram_responder.sv
// Memory-side responder for VerySimpleCPU: loads a program, runs the CPU to HALT_ADDR, then exposes results.
// Define VSC_RAM_CLEAR_EN to zero the whole memory after every reset and restart.
module vsc_ram_responder
  import vsc_pkg::*;
#(
  parameter int              SIZE      = DEF_SIZE,
  parameter logic [SIZE-1:0] HALT_ADDR = SIZE'(DEF_HALT_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SIZE-1:0]   addr_toRAM,
  input  logic              wrEn,
  input  logic [WORD_W-1:0] data_toRAM,
  output logic [WORD_W-1:0] data_fromRAM,
  output logic              cpu_rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              load_ovf,
  input  logic              start,
  input  logic [SIZE-1:0]   peek_addr,
  output logic [WORD_W-1:0] peek_data,
  output logic              done,
  output logic [WORD_W-1:0] result,
  output logic [WORD_W-1:0] run_cycles,
  output vsc_state_e        state_dbg
);

  vsc_state_e        state_q, state_d;
  logic [SIZE-1:0]   ld_ptr_q, ld_ptr_d;
  logic              load_ovf_q, load_ovf_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic [WORD_W-1:0] run_cycles_q, run_cycles_d;
  logic              cpu_rst_q;

  logic              mem_we;
  logic [SIZE-1:0]   mem_waddr;
  logic [WORD_W-1:0] mem_wdata;

  // Load handshake: a word transfers on a rising edge where ld_valid && ld_ready;
  // ld_ready depends only on state, never on ld_valid, and the host holds data until accepted.
  always_comb begin
    state_d      = state_q;
    ld_ptr_d     = ld_ptr_q;
    load_ovf_d   = load_ovf_q;
    result_d     = result_q;
    run_cycles_d = run_cycles_q;
    mem_we       = 1'b0;
    mem_waddr    = ld_ptr_q;
    mem_wdata    = ld_data;
    case (state_q)
      ST_INIT: begin
`ifdef VSC_RAM_CLEAR_EN
        state_d = ST_CLEAR;
`else
        state_d = ST_LOAD;
`endif
      end
`ifdef VSC_RAM_CLEAR_EN
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_wdata = '0;
        ld_ptr_d  = ld_ptr_q + SIZE'(1);
        // Pointer wraps back to 0 here, ready for the load.
        if (ld_ptr_q == '1) state_d = ST_LOAD;
      end
`endif
      ST_LOAD: begin
        if (ld_valid) begin
          mem_we   = 1'b1;
          ld_ptr_d = ld_ptr_q + SIZE'(1);
          if (ld_last) begin
            state_d = ST_RUN;
          end else if (ld_ptr_q == '1) begin
            load_ovf_d = 1'b1;
            state_d    = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        run_cycles_d = sat_inc(run_cycles_q);
        mem_we       = wrEn;
        mem_waddr    = addr_toRAM;
        mem_wdata    = data_toRAM;
        if (wrEn && (addr_toRAM == HALT_ADDR)) begin
          result_d = data_toRAM;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d      = ST_INIT;
          load_ovf_d   = 1'b0;
          ld_ptr_d     = '0;
          run_cycles_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      ld_ptr_q     <= '0;
      load_ovf_q   <= 1'b0;
      result_q     <= '0;
      run_cycles_q <= '0;
      cpu_rst_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      ld_ptr_q     <= ld_ptr_d;
      load_ovf_q   <= load_ovf_d;
      result_q     <= result_d;
      run_cycles_q <= run_cycles_d;
      cpu_rst_q    <= (state_d != ST_RUN);
    end
  end

  vsc_ram_array #(
    .AW(SIZE),
    .DW(WORD_W)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst),
    .we     (mem_we),
    .waddr  (mem_waddr),
    .wdata  (mem_wdata),
    .raddr_a(addr_toRAM),
    .rdata_a(data_fromRAM),
    .re_b   (state_q == ST_DONE),
    .raddr_b(peek_addr),
    .rdata_b(peek_data)
  );

  assign cpu_rst    = cpu_rst_q;
  assign ld_ready   = (state_q == ST_LOAD);
  assign done       = (state_q == ST_DONE);
  assign load_ovf   = load_ovf_q;
  assign result     = result_q;
  assign run_cycles = run_cycles_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_vsc_ram_responder.sv
// Bench for vsc_ram_responder: the bench plays host and CPU against a word-level memory model.
module tb_vsc_ram_responder;
  import vsc_pkg::*;

`ifdef VSC_RAM_CLEAR_EN
  localparam int SIZE = 10;
`else
  localparam int SIZE = 14;
`endif
  localparam int DEPTH = 2**SIZE;
  localparam logic [SIZE-1:0] HALT = '1;

  logic              clk, rst;
  logic [SIZE-1:0]   addr_toRAM;
  logic              wrEn;
  logic [31:0]       data_toRAM;
  logic [31:0]       data_fromRAM;
  logic              cpu_rst;
  logic              ld_valid, ld_ready, ld_last;
  logic [31:0]       ld_data;
  logic              load_ovf;
  logic              start;
  logic [SIZE-1:0]   peek_addr;
  logic [31:0]       peek_data;
  logic              done;
  logic [31:0]       result, run_cycles;
  vsc_state_e        state_dbg;

  vsc_ram_responder #(.SIZE(SIZE), .HALT_ADDR(HALT)) dut (
    .clk(clk), .rst(rst), .addr_toRAM(addr_toRAM), .wrEn(wrEn), .data_toRAM(data_toRAM),
    .data_fromRAM(data_fromRAM), .cpu_rst(cpu_rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .load_ovf(load_ovf), .start(start),
    .peek_addr(peek_addr), .peek_data(peek_data), .done(done), .result(result),
    .run_cycles(run_cycles), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          n_words;
    int          n_reads;
    logic [31:0] halt_val;
    logic [31:0] exp_run;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
`ifdef VSC_RAM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ld_ready && k < DEPTH + 16) begin
      tick();
      k++;
    end
    check("ld_ready_wait", 32'(ld_ready), 32'd1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_words(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = (i == 0) ? 32'h9000C005 : $urandom;
      ld_last  = use_last && (i == n - 1);
      model[i] = ld_data;
      if (i == n - 1) check("cpu_rst_before_last", 32'(cpu_rst), 32'd1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic cpu_read(input int a);
    addr_toRAM = SIZE'(a);
    wrEn = 1'b0;
    exp_q.push_back(model[a]);
    tick();
    check("cpu_read", data_fromRAM, exp_q.pop_front());
  endtask

  task automatic halt(input logic [31:0] v);
    addr_toRAM = HALT;
    data_toRAM = v;
    wrEn = 1'b1;
    model[DEPTH-1] = v;
    tick();
    wrEn = 1'b0;
    ld_valid = 1'b0;
    check("done_after_halt", 32'(done), 32'd1);
    check("cpu_rst_after_halt", 32'(cpu_rst), 32'd1);
    check("result", result, v);
  endtask

  task automatic peek(input int a);
    peek_addr = SIZE'(a);
    exp_q.push_back(model[a]);
    tick();
    check("peek", peek_data, exp_q.pop_front());
  endtask

  task automatic restart_with_peek(input int a);
    peek_addr = SIZE'(a);
    exp_q.push_back(model[a]);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("peek_with_start", peek_data, exp_q.pop_front());
    check("done_after_start", 32'(done), 32'd0);
    check("state_after_start", 32'(state_dbg), 32'(ST_INIT));
    check("ovf_after_start", 32'(load_ovf), 32'd0);
    check("run_cycles_after_start", run_cycles, 32'd0);
    model_clear();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int bad;
    logic [31:0] held;
    rst = 1'b0; addr_toRAM = '0; wrEn = 1'b0; data_toRAM = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; start = 1'b0; peek_addr = '0;

    vecs[0] = '{n_words: 3, n_reads: 2, halt_val: 32'd7,          exp_run: 32'd3};
    vecs[1] = '{n_words: 1, n_reads: 0, halt_val: 32'hDEADBEEF,   exp_run: 32'd1};
    vecs[2] = '{n_words: 5, n_reads: 4, halt_val: 32'h1234_5678,  exp_run: 32'd5};
    vecs[3] = '{n_words: 2, n_reads: 1, halt_val: 32'h0,          exp_run: 32'd2};

    tick(); tick();
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_load_ovf", 32'(load_ovf), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_run_cycles", run_cycles, 32'd0);
    check("rst_data_fromRAM", data_fromRAM, 32'd0);
    check("rst_peek_data", peek_data, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_INIT));

    rst = 1'b1;
    check("init_ld_ready", 32'(ld_ready), 32'd0);
    tick();
`ifdef VSC_RAM_CLEAR_EN
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ld_ready) bad++;
      tick();
    end
    check("clear_ready_low_cycles", 32'(bad), 32'd0);
    model_clear();
`endif
    check("ld_ready_after_init", 32'(ld_ready), 32'd1);

    // table-driven load / run / halt / peek
    for (int v = 0; v < 4; v++) begin
      load_words(vecs[v].n_words, 1'b1);
      check("cpu_rst_fall", 32'(cpu_rst), 32'd0);
      check("ld_ready_in_run", 32'(ld_ready), 32'd0);
      ld_valid = 1'b1;
      ld_data  = 32'hBAD0_BAD0;
      for (int r = 0; r < vecs[v].n_reads; r++) cpu_read(r % vecs[v].n_words);
      halt(vecs[v].halt_val);
      check("run_cycles", run_cycles, vecs[v].exp_run);
      for (int a = 0; a < vecs[v].n_words; a++) peek(a);
      peek(DEPTH - 1);
      addr_toRAM = '0; data_toRAM = ~model[0]; wrEn = 1'b1;
      tick();
      wrEn = 1'b0;
      peek(0);
      held = result;
      restart_with_peek(vecs[v].n_words > 1 ? 1 : 0);
      check("result_held", result, held);
      wait_ready();
    end

    // read-first on a same-address CPU write, then read back the new word
    load_words(4, 1'b1);
    addr_toRAM = SIZE'(3); data_toRAM = 32'hFEED_0003; wrEn = 1'b1;
    exp_q.push_back(model[3]);
    model[3] = 32'hFEED_0003;
    tick();
    wrEn = 1'b0;
    check("read_first", data_fromRAM, exp_q.pop_front());
    cpu_read(3);
    halt(32'h0000_0042);
    peek(3);
    restart_with_peek(2);
    wait_ready();

    // overflow: DEPTH words, ld_last never set
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'hA500_0000 | 32'(i);
      ld_last  = 1'b0;
      model[i] = ld_data;
      if (i == DEPTH - 1) begin
        check("ovf_ready_last_word", 32'(ld_ready), 32'd1);
        check("ovf_not_yet", 32'(load_ovf), 32'd0);
      end
      tick();
    end
    ld_valid = 1'b0;
    check("load_ovf_set", 32'(load_ovf), 32'd1);
    check("ovf_state_run", 32'(state_dbg), 32'(ST_RUN));
    check("ovf_cpu_rst", 32'(cpu_rst), 32'd0);
    halt(32'h0000_CAFE);
    peek(0);
    peek(DEPTH / 2);
    peek(DEPTH - 1);
    restart_with_peek(100);
    wait_ready();

    // reset mid-load: partial words stay in memory
    load_words(2, 1'b0);
    check("partial_still_load", 32'(state_dbg), 32'(ST_LOAD));
    rst = 1'b0;
    #1;
    check("midload_rst_state", 32'(state_dbg), 32'(ST_INIT));
    check("midload_rst_ready", 32'(ld_ready), 32'd0);
    tick();
    rst = 1'b1;
    model_clear();
    wait_ready();
    load_words(1, 1'b1);
    halt(32'h0000_0055);
    peek(0);
    peek(1);
    restart_with_peek(0);
    wait_ready();

    // reset mid-RUN, then reload and finish a run
    load_words(2, 1'b1);
    cpu_read(1);
    rst = 1'b0;
    #1;
    check("midrun_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_run_cycles", run_cycles, 32'd0);
    check("midrun_rst_result", result, 32'd0);
    tick();
    rst = 1'b1;
    model_clear();
    wait_ready();
    load_words(2, 1'b1);
    cpu_read(0);
    halt(32'h0000_0099);
    check("reload_run_cycles", run_cycles, 32'd2);
    peek(0);
    peek(1);
    peek(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
